div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
- It receives the pipeline's level-held `div_start` request and answers with a one-cycle `div_ready` pulse. The stall unit drops `div_start` on that pulse, which releases the EX/MEM/WB stall.
- Result is packed as HI = remainder and LO = quotient, written to the HI/LO registers downstream.

---
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is packed {remainder, quotient} for the HI/LO registers.
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately when
// |dividend| < |divisor| (same result, shorter latency).
module div_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                div_start,
   input  logic                div_signed,
   input  logic                div_annul,
   input  logic [DATA_W-1:0]   div_opdata1,
   input  logic [DATA_W-1:0]   div_opdata2,
   output logic                div_ready,
   output logic [2*DATA_W-1:0] div_result,
   output logic                div_busy
);

   typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                negq_q, negq_d;
   logic                negr_q, negr_d;
   logic                sgn_q, sgn_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic [2*DATA_W-1:0] result_q, result_d;

   logic                a_neg_c, b_neg_c;
   logic [DATA_W-1:0]   a_abs_c, b_abs_c;
   logic                early_c, abort_c, last_c;
   logic [DATA_W:0]     shift_c, diff_c;
   logic                qbit_c;
   logic [DATA_W-1:0]   step_rem_c, step_quo_c;
   logic [DATA_W-1:0]   fin_rem_c, fin_quo_c;

   // Operand magnitudes; only signed operations take the absolute value
   assign a_neg_c = div_signed & div_opdata1[DATA_W-1];
   assign b_neg_c = div_signed & div_opdata2[DATA_W-1];
   assign a_abs_c = a_neg_c ? -div_opdata1 : div_opdata1;
   assign b_abs_c = b_neg_c ? -div_opdata2 : div_opdata2;

`ifdef DIV_EARLY_OUT_EN
   assign early_c = (a_abs_c < b_abs_c);
`else
   assign early_c = 1'b0;
`endif

   // Annul wins over start; a dropped start also abandons the operation
   assign abort_c = div_annul | ~div_start;
   assign last_c  = (cnt_q == CNT_W'(DATA_W - 1));

   // One restoring step on the {partial remainder, dividend} pair, DATA_W+1 bit trial subtract
   assign shift_c    = {rem_q, quo_q[DATA_W-1]};
   assign diff_c     = shift_c - {1'b0, dvs_q};
   assign qbit_c     = ~diff_c[DATA_W];
   assign step_rem_c = qbit_c ? diff_c[DATA_W-1:0] : shift_c[DATA_W-1:0];
   assign step_quo_c = {quo_q[DATA_W-2:0], qbit_c};
   assign fin_quo_c  = (sgn_q & negq_q) ? -step_quo_c : step_quo_c;
   assign fin_rem_c  = (sgn_q & negr_q) ? -step_rem_c : step_rem_c;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (div_start && !div_annul) begin
               if (div_opdata2 == '0) state_d = ZERO;
               else if (early_c)      state_d = DONE;
               else                   state_d = BUSY;
            end
         end
         ZERO:    state_d = abort_c ? IDLE : DONE;
         BUSY: begin
            if (abort_c)     state_d = IDLE;
            else if (last_c) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values, keyed on the current and next state
   always_comb begin
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      sgn_d    = sgn_q;
      result_d = result_q;
      ready_d  = (state_d == DONE);
      busy_d   = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (state_d != IDLE) begin
               cnt_d  = '0;
               rem_d  = '0;
               quo_d  = a_abs_c;
               dvs_d  = b_abs_c;
               negq_d = a_neg_c ^ b_neg_c;
               negr_d = a_neg_c;
               sgn_d  = div_signed;
               if (state_d == DONE) result_d = {div_opdata1, DATA_W'(0)};
            end
         end
         ZERO: begin
            if (state_d == DONE) result_d = '0;
         end
         BUSY: begin
            if (state_d != IDLE) begin
               cnt_d = cnt_q + CNT_W'(1);
               rem_d = step_rem_c;
               quo_d = step_quo_c;
               if (state_d == DONE) result_d = {fin_rem_c, fin_quo_c};
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         sgn_q    <= sgn_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign div_ready  = ready_q;
   assign div_result = result_q;
   assign div_busy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a plain-arithmetic model.
module tb_div_unit;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned TMO    = 200;

   logic        clk = 1'b0;
   logic        resetn;
   logic        div_start;
   logic        div_signed;
   logic        div_annul;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic        div_ready;
   logic [63:0] div_result;
   logic        div_busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   div_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_annul  (div_annul),
      .div_opdata1(div_opdata1),
      .div_opdata2(div_opdata2),
      .div_ready  (div_ready),
      .div_result (div_result),
      .div_busy   (div_busy)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it differs
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Reference result: truncating division, remainder takes the dividend's sign, x/0 = 0
   function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Reference latency in cycles after the acceptance edge
   function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef DIV_EARLY_OUT_EN
      longint ma, mb;
`endif
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
      ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
`else
      if (sgn && a == 32'd0) return 33;
`endif
      return 33;
   endfunction

   // One complete operation from IDLE, checking latency, result, busy and the return to IDLE
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn);
      int          lat;
      logic [63:0] res;
      lat = 0;
      res = 'x;
      div_opdata1 = a;
      div_opdata2 = b;
      div_signed  = sgn;
      div_start   = 1'b1;
      @(posedge clk);
      #1;
      div_opdata1 = $urandom;
      div_opdata2 = $urandom;
      div_signed  = 1'($urandom_range(0, 1));
      for (int c = 1; c <= int'(TMO); c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (c == 1) chk({tag, " busy"}, 64'(div_busy), 64'd1);
         if (div_ready) begin
            lat = c;
            res = div_result;
            break;
         end
      end
      div_start = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(model_lat(a, b, sgn)));
      chk({tag, " result"}, res, model_res(a, b, sgn));
      @(posedge clk);
      #1;
      chk({tag, " idle"}, {62'd0, div_busy, div_ready}, 64'd0);
   endtask

   // Start an operation and abort it by annul or by dropping start after n cycles
   task automatic abort_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int n, input logic use_annul, input logic [63:0] prev);
      logic seen;
      seen = 1'b0;
      div_opdata1 = a;
      div_opdata2 = b;
      div_signed  = 1'b0;
      div_start   = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= n; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         seen = seen | div_ready;
      end
      if (use_annul) div_annul = 1'b1;
      else           div_start = 1'b0;
      @(posedge clk);
      #1;
      seen = seen | div_ready;
      chk({tag, " busy"}, 64'(div_busy), 64'd0);
      chk({tag, " no ready"}, 64'(seen), 64'd0);
      chk({tag, " result kept"}, div_result, prev);
      div_annul = 1'b0;
      div_start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " stays idle"}, 64'(div_busy), 64'd0);
   endtask

   initial begin
      logic [63:0] prev;
      logic [31:0] ra, rb;
      logic        rs;
      int          r1, r2, exp1;

      resetn      = 1'b0;
      div_start   = 1'b0;
      div_signed  = 1'b0;
      div_annul   = 1'b0;
      div_opdata1 = '0;
      div_opdata2 = '0;
      #12;
      chk("reset outputs", {div_result[62:0], div_busy}, 64'd0);
      chk("reset ready", 64'(div_ready), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases from the arithmetic rules
      run_op("divu 100/7", 32'd100, 32'd7, 1'b0);
      run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("div 5/0", 32'd5, 32'd0, 1'b1);
      run_op("divu 3/10", 32'd3, 32'd10, 1'b0);
      run_op("div -3/10", 32'hFFFF_FFFD, 32'd10, 1'b1);
      run_op("div 100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1);
      run_op("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("divu max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("divu 0/9", 32'd0, 32'd9, 1'b0);

      // Abort by annul mid-BUSY, then a fresh operation
      prev = model_res(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("divu 7/7", 32'd7, 32'd7, 1'b0);
      prev = model_res(32'd7, 32'd7, 1'b0);
      abort_op("annul busy", 32'hFFFF_FFFF, 32'd3, 10, 1'b1, prev);
      run_op("divu 9/3", 32'd9, 32'd3, 1'b0);
      prev = model_res(32'd9, 32'd3, 1'b0);
      abort_op("drop start", 32'h1234_5678, 32'h11, 5, 1'b0, prev);
      abort_op("annul zero", 32'd5, 32'd0, 1, 1'b1, prev);

      // Annul has priority over start in IDLE
      div_opdata1 = 32'd50;
      div_opdata2 = 32'd5;
      div_start   = 1'b1;
      div_annul   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("annul in idle", {62'd0, div_busy, div_ready}, 64'd0);
      div_start = 1'b0;
      div_annul = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back with start held across ready
      exp1 = model_lat(32'd100, 32'd7, 1'b0);
      r1 = 0;
      r2 = 0;
      div_opdata1 = 32'd100;
      div_opdata2 = 32'd7;
      div_signed  = 1'b0;
      div_start   = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= int'(TMO); c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (div_ready && r1 == 0) r1 = c;
         else if (div_ready) begin
            r2 = c;
            break;
         end
      end
      div_start = 1'b0;
      chk("b2b first ready", 64'(r1), 64'(exp1));
      chk("b2b second ready", 64'(r2), 64'(2 * exp1 + 1));
      chk("b2b result", div_result, model_res(32'd100, 32'd7, 1'b0));
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of an operation
      div_opdata1 = 32'd1000;
      div_opdata2 = 32'd3;
      div_start   = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("async reset", {div_result[62:0], div_busy}, 64'd0);
      chk("async reset ready", 64'(div_ready), 64'd0);
      div_start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      run_op("divu 20/6", 32'd20, 32'd6, 1'b0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = -32'($urandom_range(1, 20));
            3: ra = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), ra, rb, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
